gcd_unit: RTL

- Parametrised, self-contained subtractive GCD engine with an integrated FSM and datapath.
- Successor to the fixed-width controller/datapath pair.
- Adds a WIDTH parameter, asynchronous reset, a clean start/busy/done handshake, zero-operand handling and a result hold register.
- Sits as a compute slave behind a register block or sequencer, which supplies operands and polls or waits on done.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_datapath.sv | 55 +++++
 rtl/gcd_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: FSM state encoding
// and a helper that sizes the optional iteration counter.
package gcd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_t;

    // The worst case (1, 2^W-1) takes 2^W-2 subtractions, which still fits in W bits.
    function automatic int min_cnt_w(input int width);
        return width;
    endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, magnitude comparator, subtractor and result hold
// register for the subtractive GCD engine. All sequencing comes from gcd_unit.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             sel_sub_a,
    input  logic             sel_sub_b,
    input  logic             res_ld,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             a_zero,
    output logic             b_zero,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    assign eq     = (a_q == b_q);
    assign lt     = (a_q < b_q);
    assign gt     = (a_q > b_q);
    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);

    // Operand capture, then the larger operand is reduced by the smaller one
    // so the subtraction can never wrap; the result is held between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            if (ld) begin
                a_q <= a_in;
                b_q <= b_in;
            end else if (sel_sub_a) begin
                a_q <= a_q - b_q;
            end else if (sel_sub_b) begin
                b_q <= b_q - a_q;
            end
            if (res_ld) begin
                result <= a_zero ? b_q : a_q;
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Parametrised subtractive GCD engine with start/busy/done handshake.
// Optional iteration counter output is enabled by defining GCD_ITER_CNT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start after reset, no result yet
// S_CALC | reducing operands, one subtraction per clock
// S_DONE | result held on gcd_out, done high until next accepted start
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef GCD_ITER_CNT_EN
    ,
    parameter int CNT_W = WIDTH + 1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    state_t state;

    logic eq;
    logic lt;
    logic gt;
    logic a_zero;
    logic b_zero;
    logic accept;
    logic finish;
    logic sub_a;
    logic sub_b;

    // start is ignored while computing, so operands are only re-sampled in IDLE/DONE
    assign accept = start && (state != S_CALC);
    assign finish = (state == S_CALC) && (a_zero || b_zero || eq);
    assign sub_a  = (state == S_CALC) && !finish && gt;
    assign sub_b  = (state == S_CALC) && !finish && lt;

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    gcd_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (accept),
        .sel_sub_a(sub_a),
        .sel_sub_b(sub_b),
        .res_ld   (finish),
        .a_in     (a_in),
        .b_in     (b_in),
        .eq       (eq),
        .lt       (lt),
        .gt       (gt),
        .a_zero   (a_zero),
        .b_zero   (b_zero),
        .result   (gcd_out)
    );

    // Sequencing FSM with the registered status flags it owns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            zero_err <= 1'b0;
`ifdef GCD_ITER_CNT_EN
            iter_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= S_CALC;
                        zero_err <= 1'b0;
`ifdef GCD_ITER_CNT_EN
                        iter_cnt <= '0;
`endif
                    end
                end
                S_CALC: begin
                    if (finish) begin
                        state    <= S_DONE;
                        zero_err <= a_zero && b_zero;
                    end
`ifdef GCD_ITER_CNT_EN
                    else begin
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
